// File: rtl/calculation_seq.sv
// Sequential six-result calculation unit: one operand set per valid/ready
// transaction, modulo via an iterative restoring divider (one bit per cycle).
module calculation_seq #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic [BW-1:0] c,
    input  logic [BW-1:0] d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] s1,
    output logic [BW-1:0] s2,
    output logic [BW-1:0] s3,
    output logic [BW-1:0] s4,
    output logic [BW-1:0] s5,
    output logic [BW-1:0] s6,
    output logic          div_by_zero
);

    localparam int CW = $clog2(BW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    typedef struct packed {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] c;
        logic [BW-1:0] d;
    } opnd_t;

    logic [1:0]    state;
    opnd_t         opnd_q;
    logic [BW:0]   rem;
    logic [CW-1:0] cnt;
    logic          fin;

    logic [BW:0]   shifted;
    logic [BW:0]   rem_step;
    logic [BW-1:0] mod_r;
    logic [BW-1:0] prod;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted  = {rem[BW-1:0], opnd_q.a[cnt]};
        rem_step = (shifted >= {1'b0, opnd_q.b}) ? shifted - {1'b0, opnd_q.b} : shifted;
        mod_r    = (opnd_q.b == '0) ? opnd_q.a : rem[BW-1:0];
        prod     = opnd_q.a * opnd_q.b;
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            opnd_q      <= '0;
            rem         <= '0;
            cnt         <= '0;
            fin         <= 1'b0;
            out_valid   <= 1'b0;
            s1          <= '0;
            s2          <= '0;
            s3          <= '0;
            s4          <= '0;
            s5          <= '0;
            s6          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    opnd_q <= '{a: a, b: b, c: c, d: d};
                    rem    <= '0;
                    cnt    <= CW'(BW - 1);
                    fin    <= 1'b0;
                    state  <= DIV;
                end
                DIV: if (!fin) begin
                    rem <= rem_step;
                    if (cnt == '0) fin <= 1'b1;
                    else           cnt <= cnt - CW'(1);
                end else begin
                    // Results are formed from the settled remainder of the last step.
                    s1          <= opnd_q.a + opnd_q.b;
                    s2          <= prod;
                    s3          <= mod_r + opnd_q.d;
                    s4          <= opnd_q.c + opnd_q.d + prod;
                    s5          <= opnd_q.a - opnd_q.b;
                    s6          <= prod + opnd_q.a + opnd_q.d + opnd_q.c - opnd_q.b;
                    div_by_zero <= (opnd_q.b == '0);
                    out_valid   <= 1'b1;
                    state       <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calculation_seq.sv
// Scoreboard bench for calculation_seq: BW=8 main instance plus a BW=16 instance.
module tb_calculation_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready, dbz;
    logic [7:0] a, b, c, d, s1, s2, s3, s4, s5, s6;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_dbz;
    logic [15:0] wa, wb, wc, wd, w1, w2, w3, w4, w5, w6;

    calculation_seq #(.BW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6), .div_by_zero(dbz)
    );

    calculation_seq #(.BW(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(wa), .b(wb), .c(wc), .d(wd), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .s1(w1), .s2(w2), .s3(w3), .s4(w4), .s5(w5), .s6(w6), .div_by_zero(w_dbz)
    );

    typedef struct packed {
        logic [7:0] s1, s2, s3, s4, s5, s6;
        logic       dbz;
    } res_t;

    res_t exp_q[$];
    res_t last_exp;
    int   passed = 0;
    int   total  = 0;

    function automatic res_t model(input logic [7:0] ma, mb, mc, md);
        res_t r;
        logic [7:0] bp1, t6, rm;
        rm    = (mb == 8'd0) ? ma : (ma % mb);
        bp1   = mb + 8'd1;
        t6    = bp1 * ma;
        r.s1  = ma + mb;
        r.s2  = ma * mb;
        r.s3  = rm + md;
        r.s4  = mc + md + r.s2;
        r.s5  = ma - mb;
        r.s6  = t6 + md + mc - mb;
        r.dbz = (mb == 8'd0);
        return r;
    endfunction

    function automatic res_t observed();
        return {s1, s2, s3, s4, s5, s6, dbz};
    endfunction

    // Present one set, push its expectation on accept, pop when the result appears.
    // Returns just after the edge that raised out_valid (handshake not yet taken).
    task automatic send(input logic [7:0] ia, ib, ic, id, input string tag);
        bit   ok;
        int   n;
        res_t g;
        a = ia; b = ib; c = ic; d = id;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++;
        if (!ok) $display("FAIL %s accept: in_ready never seen high", tag);
        else passed++;
        exp_q.push_back(model(ia, ib, ic, id));
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== 9) $display("FAIL %s latency: got %0d edges, want 9", tag, n);
        else passed++;
        last_exp = exp_q.pop_front();
        g = observed();
        total++;
        if (g !== last_exp) $display("FAIL %s result: got %h want %h", tag, g, last_exp);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b1;
        wa = '0; wb = '0; wc = '0; wd = '0;
        #21;
        total++;
        if ({in_ready, out_valid, observed()} !== {1'b1, 1'b0, 49'd0})
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h want 1 0 0", in_ready, out_valid, observed());
        else passed++;
        total++;
        if ({w_in_ready, w_out_valid, w3, w5} !== {1'b1, 1'b0, 32'd0})
            $display("FAIL reset_state16: got rdy=%b vld=%b s3=%0d s5=%0d", w_in_ready, w_out_valid, w3, w5);
        else passed++;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(8'd200, 8'd7, 8'd10, 8'd3, "basic");
        total++;
        if ({s1, s2, s3, s4, s5, s6, dbz} !== {8'd207, 8'd120, 8'd7, 8'd133, 8'd193, 8'd70, 1'b0})
            $display("FAIL basic_const: got %0d %0d %0d %0d %0d %0d %b want 207 120 7 133 193 70 0",
                     s1, s2, s3, s4, s5, s6, dbz);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL basic_handshake: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_wrap();
        send(8'd255, 8'd1, 8'd255, 8'd255, "wrap");
        total++;
        if ({s1, s2, s3, s4, s5, s6} !== {8'd0, 8'd255, 8'd255, 8'd253, 8'd254, 8'd251})
            $display("FAIL wrap_const: got %0d %0d %0d %0d %0d %0d want 0 255 255 253 254 251",
                     s1, s2, s3, s4, s5, s6);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        send(8'd5, 8'd0, 8'd1, 8'd2, "divzero");
        total++;
        if ({s1, s2, s3, s4, s5, s6, dbz} !== {8'd5, 8'd0, 8'd7, 8'd3, 8'd5, 8'd8, 1'b1})
            $display("FAIL divzero_const: got %0d %0d %0d %0d %0d %0d %b want 5 0 7 3 5 8 1",
                     s1, s2, s3, s4, s5, s6, dbz);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(8'd123, 8'd11, 8'd45, 8'd67, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready, observed()} !== {1'b1, 1'b0, last_exp})
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b res=%h want 1 0 %h",
                         i, out_valid, in_ready, observed(), last_exp);
            else passed++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL bp_no_capture: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset_mid_div();
        bit seen;
        a = 8'd77; b = 8'd5; c = 8'd9; d = 8'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, observed()} !== {1'b1, 1'b0, 49'd0})
            $display("FAIL rst_mid: got rdy=%b vld=%b res=%h want 1 0 0", in_ready, out_valid, observed());
        else passed++;
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_abort: got out_valid_seen=%b rdy=%b want 0 1", seen, in_ready);
        else passed++;
        send(8'd9, 8'd4, 8'd0, 8'd0, "after_rst");
        total++;
        if (s3 !== 8'd1) $display("FAIL after_rst_s3: got %0d want 1", s3);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom), (i == 3) ? 8'd0 : 8'($urandom), 8'($urandom), 8'($urandom), "b2b");
        end
        @(posedge clk); #1;
        total++;
        if (exp_q.size() !== 0) $display("FAIL b2b_queue: got %0d left want 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_bw16();
        int n;
        wa = 16'd50000; wb = 16'd300; wc = 16'd0; wd = 16'd0;
        w_out_ready = 1'b1;
        w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        n = 0;
        while (!w_out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== 17) $display("FAIL bw16_latency: got %0d edges want 17", n);
        else passed++;
        total++;
        if ({w1, w3, w5, w_dbz} !== {16'd50300, 16'd200, 16'd49700, 1'b0})
            $display("FAIL bw16_result: got s1=%0d s3=%0d s5=%0d dbz=%b want 50300 200 49700 0",
                     w1, w3, w5, w_dbz);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({w_out_valid, w_in_ready} !== 2'b01)
            $display("FAIL bw16_handshake: got vld=%b rdy=%b want 0 1", w_out_valid, w_in_ready);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_div_zero();
        test_backpressure();
        test_reset_mid_div();
        test_back_to_back();
        test_bw16();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
